// File: rtl/fc3_tree_seq.sv
// Chunk sequencer for the fc3 adder tree: steps the tree input mux over the
// chunks of one vector, tracks them through the tree latency and sums the results.
module fc3_tree_seq #(
  parameter int NCHK = 4,
  parameter int TWID = 22,
  parameter int LAT  = 6,
  parameter int SWID = (NCHK > 1) ? $clog2(NCHK) : 1,
  parameter int LWID = $clog2(NCHK + 1),
  parameter int AWID = TWID + ((NCHK > 1) ? $clog2(NCHK) : 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic [LWID-1:0] iLen,
  output logic            oBusy,
  output logic            oIssue,
  output logic [SWID-1:0] oSel,
  input  logic [TWID-1:0] tData,
  output logic [AWID-1:0] oData,
  output logic            oValid,
  input  logic            oReady
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LWID-1:0] LEN_MAX = LWID'(NCHK);

  // A zero or oversized request means a full-length vector.
  function automatic logic [LWID-1:0] clamp_len(input logic [LWID-1:0] len);
    if ((len == '0) || (len > LEN_MAX)) begin
      return LEN_MAX;
    end
    return len;
  endfunction

  // Unsigned accumulate; anything above AWID wraps away.
  function automatic logic [AWID-1:0] acc_add(input logic [AWID-1:0] acc,
                                               input logic [TWID-1:0] term);
    return acc + AWID'(term);
  endfunction

  logic [1:0]      state_q, state_d;
  logic [LWID-1:0] len_q, len_d;
  logic [SWID-1:0] idx_q, idx_d;
  logic [LWID-1:0] cnt_q, cnt_d;
  logic [AWID-1:0] acc_q, acc_d;
  logic [LAT-1:0]  trk_q, trk_d;

  logic issue;
  logic ret;
  logic idx_last;

  assign issue    = (state_q == ST_ISSUE);
  assign ret      = trk_q[LAT-1];
  assign idx_last = (LWID'(idx_q) == (len_q - LWID'(1)));

  assign oBusy  = (state_q != ST_IDLE);
  assign oIssue = issue;
  assign oSel   = issue ? idx_q : '0;
  assign oValid = (state_q == ST_DONE);
  assign oData  = acc_q;

  // In-flight tracker: bit LAT-1 marks the cycle a chunk's sum is on tData.
  always_comb begin
    trk_d    = '0;
    trk_d[0] = issue;
    for (int i = 1; i < LAT; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    if (ret) begin
      acc_d = acc_add(acc_q, tData);
      cnt_d = cnt_q + LWID'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          len_d   = clamp_len(iLen);
          acc_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        idx_d = idx_q + SWID'(1);
        if (idx_last) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ret && (cnt_d == len_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (oReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      trk_q   <= trk_d;
    end
  end

endmodule

// File: tb/tb_fc3_tree_seq.sv
// Scoreboard bench for fc3_tree_seq: stimulus schedules tree results per cycle
// and queues expected sums; a negedge monitor checks issue timing and results.
module tb_fc3_tree_seq;
  localparam int NCHK = 4;
  localparam int TWID = 22;
  localparam int LAT  = 6;
  localparam int SWID = 2;
  localparam int LWID = 3;
  localparam int AWID = 24;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iStart = 1'b0;
  logic [LWID-1:0] iLen = '0;
  logic [TWID-1:0] tData = '0;
  logic            oReady = 1'b1;
  logic            oBusy, oIssue, oValid;
  logic [SWID-1:0] oSel;
  logic [AWID-1:0] oData;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit hot = 1'b0;
  bit rand_ready = 1'b0;

  logic [TWID-1:0] sched[int];
  int              iss_sched[int];
  typedef struct {
    int              cyc;
    logic [AWID-1:0] sum;
  } exp_t;
  exp_t expq[$];
  logic [TWID-1:0] fv[NCHK];

  bit              vprev = 1'b0;
  bit              hs_prev = 1'b0;
  logic [AWID-1:0] held = '0;

  fc3_tree_seq #(.NCHK(NCHK), .TWID(TWID), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iLen(iLen),
    .oBusy(oBusy), .oIssue(oIssue), .oSel(oSel), .tData(tData),
    .oData(oData), .oValid(oValid), .oReady(oReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: expected event did not occur in time", name, cyc);
  endtask

  // Advance one cycle, then drive this cycle's inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (sched.exists(cyc)) tData = sched[cyc];
    else tData = hot ? {TWID{1'b1}} : TWID'($urandom);
    if (rand_ready) oReady = 1'($urandom_range(0, 1));
  endtask

  // mode 0: random chunk sums, 1: values from fv, 2: all ones
  task automatic start_vec(input int l, input int mode);
    int              len;
    int              s;
    longint          sum;
    logic [TWID-1:0] v;
    exp_t            e;
    len = (l == 0 || l > NCHK) ? NCHK : l;
    s   = cyc;
    sum = 0;
    chk("busy_before_start", oBusy, 0);
    for (int k = 0; k < len; k++) begin
      v = (mode == 1) ? fv[k] : (mode == 2) ? {TWID{1'b1}} : TWID'($urandom);
      sched[s + 1 + k + LAT] = v;
      iss_sched[s + 1 + k] = k;
      sum += v;
    end
    e.cyc = s + 1 + len + LAT;
    e.sum = AWID'(sum);
    expq.push_back(e);
    iLen   = LWID'(l);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("busy_after_start", oBusy, 1);
  endtask

  task automatic wait_idle(input bit ign);
    for (int i = 0; i < 300; i++) begin
      if (!oBusy) begin
        iStart = 1'b0;
        return;
      end
      iStart = ign && ($urandom_range(0, 2) == 0);
      step();
    end
    iStart = 1'b0;
    fail_now("idle_timeout");
  endtask

  task automatic wait_valid(input bit ign);
    for (int i = 0; i < 60; i++) begin
      if (oValid) begin
        iStart = 1'b0;
        return;
      end
      iStart = ign && ($urandom_range(0, 1) == 0);
      step();
    end
    iStart = 1'b0;
    fail_now("valid_timeout");
  endtask

  // Monitor: issue schedule every cycle, result value/timing on each new oValid.
  always @(negedge clk) begin
    if (!rst_n) begin
      vprev   = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (iss_sched.exists(cyc)) begin
        chk("issue", oIssue, 1);
        chk("sel", oSel, iss_sched[cyc]);
      end else begin
        chk("no_issue", oIssue, 0);
        chk("sel_zero", oSel, 0);
      end
      if (hs_prev) begin
        chk("valid_fall", oValid, 0);
      end else if (oValid && !vprev) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL valid_unexpected cycle %0d: got oValid=1, required 0", cyc);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("sum", oData, e.sum);
        end
      end else if (oValid) begin
        chk("data_hold", oData, held);
      end
      if (!oValid && expq.size() > 0 && cyc > expq[0].cyc) begin
        fail_now("valid_late");
        void'(expq.pop_front());
      end
      vprev   = oValid;
      held    = oData;
      hs_prev = oValid && oReady;
    end
  end

  initial begin
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", oBusy, 0);
    chk("rst_issue", oIssue, 0);
    chk("rst_sel", oSel, 0);
    chk("rst_data", oData, 0);
    chk("rst_valid", oValid, 0);
    rst_n = 1'b1;

    hot = 1'b1;
    repeat (20) step();
    chk("idle_data", oData, 0);
    chk("idle_valid", oValid, 0);
    chk("idle_busy", oBusy, 0);
    hot = 1'b0;

    fv[0] = 10; fv[1] = 20; fv[2] = 30; fv[3] = 40;
    start_vec(4, 1);
    wait_idle(1'b0);

    oReady = 1'b0;
    start_vec(0, 2);
    wait_valid(1'b0);
    repeat (5) step();
    chk("bp_valid_held", oValid, 1);
    chk("bp_data", oData, 24'hFFFFFC);
    oReady = 1'b1;
    step();
    chk("bp_idle", oBusy, 0);
    chk("bp_data_kept", oData, 24'hFFFFFC);

    fv[0] = 7;
    start_vec(1, 1);
    wait_idle(1'b0);

    oReady = 1'b0;
    start_vec(4, 0);
    repeat (3) begin
      iStart = 1'b1;
      step();
    end
    wait_valid(1'b1);
    oReady = 1'b1;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("hs_start_ignored", oBusy, 0);
    repeat (3) step();

    start_vec(4, 0);
    repeat (4) step();
    rst_n = 1'b0;
    iss_sched.delete();
    expq.delete();
    step();
    rst_n = 1'b1;
    chk("midrst_busy", oBusy, 0);
    chk("midrst_valid", oValid, 0);
    chk("midrst_data", oData, 0);
    fv[0] = 5; fv[1] = 6;
    start_vec(2, 1);
    wait_idle(1'b0);
    chk("midrst_sum", oData, 11);

    rand_ready = 1'b1;
    repeat (12) begin
      start_vec(int'($urandom_range(0, 7)), 0);
      wait_idle(1'b1);
    end
    rand_ready = 1'b0;
    oReady = 1'b1;
    repeat (5) step();
    chk("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
